// File: rtl/ddr_burst_arbiter_pkg.sv
// ddr_arb_pkg: shared constants and helpers for ddr_burst_arbiter.
//   - FSM state encoding (IDLE / ISSUE / BUSY)
//   - source identifiers (P0W, P0R, P1W, P1R)
//   - is_wr(): true when a source id names a write requester
package ddr_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    localparam logic [1:0] SRC_P0W = 2'd0;
    localparam logic [1:0] SRC_P0R = 2'd1;
    localparam logic [1:0] SRC_P1W = 2'd2;
    localparam logic [1:0] SRC_P1R = 2'd3;

    // Even source ids are write requesters, odd ids are read requesters.
    function automatic logic is_wr(input logic [1:0] src);
        return (src[0] == 1'b0);
    endfunction

endpackage

// File: rtl/ddr_burst_arbiter_rr_pick4.sv
// rr_pick4: combinational 4-way round-robin picker.
//   req        in  4 : request vector, bit index = source id
//   last_grant in  2 : most recently served source
//   valid      out 1 : at least one request present
//   idx        out 2 : first requester after last_grant (wrapping mod 4)
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last_grant,
    output logic       valid,
    output logic [1:1-1+1] idx_unused_guard_n,
    output logic [1:0] idx
);
    import ddr_arb_pkg::*;

    assign idx_unused_guard_n = 1'b0;

    // Walk offsets from 4 down to 1 so the smallest offset (last_grant+1)
    // is assigned last and therefore wins; offset 4 is last_grant itself.
    always_comb begin
        logic [1:0] cand;
        valid = 1'b0;
        idx   = 2'd0;
        cand  = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = last_grant + k[1:0];
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter: shares one DDR burst engine (write + read master)
// between two ports, each with a write and a read burst requester.
// Exactly one burst is outstanding; sources are served round-robin.
//   ui_clk / ui_rst_n          : clock, async active-low reset
//   wr_/rd_burst_req/addr/len_n: level requests and commands from port n
//   wr_/rd_ready_n             : port may request (high only in IDLE)
//   wr_fifo_re_n / rd_fifo_we_n: engine strobes gated to the granted source
//   wr_fifo_data_n / rd_fifo_data_n : write data in, read data broadcast
//   wr_/rd_burst_finish_n      : engine finish routed to granted source
//   m_*                        : command/strobe/data interface to the engine
//   grant_id, busy, proto_err  : status (proto_err sticky on bad finish)
module ddr_burst_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int LW = 10,
    parameter int DW = 64
) (
    input  logic          ui_clk,
    input  logic          ui_rst_n,
    input  logic          wr_burst_req_0,
    input  logic [AW-1:0] wr_burst_addr_0,
    input  logic [LW-1:0] wr_burst_len_0,
    output logic          wr_ready_0,
    output logic          wr_fifo_re_0,
    input  logic [DW-1:0] wr_fifo_data_0,
    output logic          wr_burst_finish_0,
    input  logic          rd_burst_req_0,
    input  logic [AW-1:0] rd_burst_addr_0,
    input  logic [LW-1:0] rd_burst_len_0,
    output logic          rd_ready_0,
    output logic          rd_fifo_we_0,
    output logic [DW-1:0] rd_fifo_data_0,
    output logic          rd_burst_finish_0,
    input  logic          wr_burst_req_1,
    input  logic [AW-1:0] wr_burst_addr_1,
    input  logic [LW-1:0] wr_burst_len_1,
    output logic          wr_ready_1,
    output logic          wr_fifo_re_1,
    input  logic [DW-1:0] wr_fifo_data_1,
    output logic          wr_burst_finish_1,
    input  logic          rd_burst_req_1,
    input  logic [AW-1:0] rd_burst_addr_1,
    input  logic [LW-1:0] rd_burst_len_1,
    output logic          rd_ready_1,
    output logic          rd_fifo_we_1,
    output logic [DW-1:0] rd_fifo_data_1,
    output logic          rd_burst_finish_1,
    output logic          m_wr_burst_req,
    output logic [AW-1:0] m_wr_burst_addr,
    output logic [LW-1:0] m_wr_burst_len,
    input  logic          m_wr_ready,
    input  logic          m_wr_fifo_re,
    output logic [DW-1:0] m_wr_fifo_data,
    input  logic          m_wr_burst_finish,
    output logic          m_rd_burst_req,
    output logic [AW-1:0] m_rd_burst_addr,
    output logic [LW-1:0] m_rd_burst_len,
    input  logic          m_rd_ready,
    input  logic          m_rd_fifo_we,
    input  logic [DW-1:0] m_rd_fifo_data,
    input  logic          m_rd_burst_finish,
    output logic [1:0]    grant_id,
    output logic          busy,
    output logic          proto_err
);

    logic [1:0]    state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    last_q, last_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] len_q, len_d;
    logic          perr_q, perr_d;

    logic          pick_valid_s;
    logic [1:0]    pick_idx_s;
    logic [0:0]    pick_guard_s;
    logic [AW-1:0] src_addr_s;
    logic [LW-1:0] src_len_s;
    logic          grant_wr_s, idle_s, busy_s, in_busy_s;
    logic          eng_ready_s, own_finish_s, bad_finish_s;

    rr_pick4 u_pick (
        .req                (({rd_burst_req_1, wr_burst_req_1, rd_burst_req_0, wr_burst_req_0})),
        .last_grant         (last_q),
        .valid              (pick_valid_s),
        .idx_unused_guard_n (pick_guard_s),
        .idx                (pick_idx_s)
    );

    assign grant_wr_s   = is_wr(grant_q);
    assign idle_s       = (state_q == ST_IDLE);
    assign busy_s       = ~idle_s;
    assign in_busy_s    = (state_q == ST_BUSY);
    assign eng_ready_s  = grant_wr_s ? m_wr_ready : m_rd_ready;
    assign own_finish_s = grant_wr_s ? m_wr_burst_finish : m_rd_burst_finish;
    // Any finish outside BUSY, or from the engine side not owning the burst.
    assign bad_finish_s = (m_wr_burst_finish & ~(in_busy_s &  grant_wr_s)) |
                          (m_rd_burst_finish & ~(in_busy_s & ~grant_wr_s));

    // Select the command of the source the picker chose.
    always_comb begin
        case (pick_idx_s)
            SRC_P0W: begin src_addr_s = wr_burst_addr_0; src_len_s = wr_burst_len_0; end
            SRC_P0R: begin src_addr_s = rd_burst_addr_0; src_len_s = rd_burst_len_0; end
            SRC_P1W: begin src_addr_s = wr_burst_addr_1; src_len_s = wr_burst_len_1; end
            SRC_P1R: begin src_addr_s = rd_burst_addr_1; src_len_s = rd_burst_len_1; end
            default: begin src_addr_s = {AW{1'b0}};      src_len_s = {LW{1'b0}};      end
        endcase
    end

    // Next-state logic: grant is committed at capture and not withdrawn.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        len_d   = len_q;
        perr_d  = perr_q | bad_finish_s;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_d = ST_ISSUE;
                    grant_d = pick_idx_s;
                    addr_d  = src_addr_s;
                    len_d   = src_len_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (eng_ready_s) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_BUSY: begin
                if (own_finish_s) begin
                    state_d = ST_IDLE;
                    last_d  = grant_q;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; last_grant resets to P1R so P0W is served first.
    always_ff @(posedge ui_clk or negedge ui_rst_n) begin
        if (!ui_rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= SRC_P0W;
            last_q  <= SRC_P1R;
            addr_q  <= {AW{1'b0}};
            len_q   <= {LW{1'b0}};
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            perr_q  <= perr_d;
        end
    end

    // Write data comes from the granted write port, zero otherwise.
    always_comb begin
        if (busy_s && (grant_q == SRC_P0W)) begin
            m_wr_fifo_data = wr_fifo_data_0;
        end else if (busy_s && (grant_q == SRC_P1W)) begin
            m_wr_fifo_data = wr_fifo_data_1;
        end else begin
            m_wr_fifo_data = {DW{1'b0}};
        end
    end

    assign m_wr_burst_req  = (state_q == ST_ISSUE) &  grant_wr_s & m_wr_ready;
    assign m_rd_burst_req  = (state_q == ST_ISSUE) & ~grant_wr_s & m_rd_ready;
    assign m_wr_burst_addr = addr_q;
    assign m_wr_burst_len  = len_q;
    assign m_rd_burst_addr = addr_q;
    assign m_rd_burst_len  = len_q;

    assign wr_ready_0 = idle_s;
    assign rd_ready_0 = idle_s;
    assign wr_ready_1 = idle_s;
    assign rd_ready_1 = idle_s;

    assign wr_fifo_re_0 = m_wr_fifo_re & busy_s & (grant_q == SRC_P0W);
    assign wr_fifo_re_1 = m_wr_fifo_re & busy_s & (grant_q == SRC_P1W);
    assign rd_fifo_we_0 = m_rd_fifo_we & busy_s & (grant_q == SRC_P0R);
    assign rd_fifo_we_1 = m_rd_fifo_we & busy_s & (grant_q == SRC_P1R);
    assign rd_fifo_data_0 = m_rd_fifo_data;
    assign rd_fifo_data_1 = m_rd_fifo_data;

    assign wr_burst_finish_0 = m_wr_burst_finish & in_busy_s & (grant_q == SRC_P0W);
    assign wr_burst_finish_1 = m_wr_burst_finish & in_busy_s & (grant_q == SRC_P1W);
    assign rd_burst_finish_0 = m_rd_burst_finish & in_busy_s & (grant_q == SRC_P0R);
    assign rd_burst_finish_1 = m_rd_burst_finish & in_busy_s & (grant_q == SRC_P1R);

    assign grant_id  = grant_q;
    assign busy      = busy_s;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Directed self-checking bench for ddr_burst_arbiter.
module tb_ddr_burst_arbiter;

    localparam int AW = 32;
    localparam int LW = 10;
    localparam int DW = 64;

    logic ui_clk, ui_rst_n;
    logic wr_burst_req_0, rd_burst_req_0, wr_burst_req_1, rd_burst_req_1;
    logic [AW-1:0] wr_burst_addr_0, rd_burst_addr_0, wr_burst_addr_1, rd_burst_addr_1;
    logic [LW-1:0] wr_burst_len_0, rd_burst_len_0, wr_burst_len_1, rd_burst_len_1;
    logic wr_ready_0, rd_ready_0, wr_ready_1, rd_ready_1;
    logic wr_fifo_re_0, wr_fifo_re_1, rd_fifo_we_0, rd_fifo_we_1;
    logic [DW-1:0] wr_fifo_data_0, wr_fifo_data_1, rd_fifo_data_0, rd_fifo_data_1;
    logic wr_burst_finish_0, wr_burst_finish_1, rd_burst_finish_0, rd_burst_finish_1;
    logic m_wr_burst_req, m_rd_burst_req;
    logic [AW-1:0] m_wr_burst_addr, m_rd_burst_addr;
    logic [LW-1:0] m_wr_burst_len, m_rd_burst_len;
    logic m_wr_ready, m_wr_fifo_re, m_wr_burst_finish;
    logic m_rd_ready, m_rd_fifo_we, m_rd_burst_finish;
    logic [DW-1:0] m_wr_fifo_data, m_rd_fifo_data;
    logic [1:0] grant_id;
    logic busy, proto_err;

    int errors = 0;
    int checks = 0;
    int re0_cnt, re1_cnt, we_cnt;

    ddr_burst_arbiter #(.AW(AW), .LW(LW), .DW(DW)) dut (
        .ui_clk(ui_clk), .ui_rst_n(ui_rst_n),
        .wr_burst_req_0(wr_burst_req_0), .wr_burst_addr_0(wr_burst_addr_0), .wr_burst_len_0(wr_burst_len_0),
        .wr_ready_0(wr_ready_0), .wr_fifo_re_0(wr_fifo_re_0), .wr_fifo_data_0(wr_fifo_data_0),
        .wr_burst_finish_0(wr_burst_finish_0),
        .rd_burst_req_0(rd_burst_req_0), .rd_burst_addr_0(rd_burst_addr_0), .rd_burst_len_0(rd_burst_len_0),
        .rd_ready_0(rd_ready_0), .rd_fifo_we_0(rd_fifo_we_0), .rd_fifo_data_0(rd_fifo_data_0),
        .rd_burst_finish_0(rd_burst_finish_0),
        .wr_burst_req_1(wr_burst_req_1), .wr_burst_addr_1(wr_burst_addr_1), .wr_burst_len_1(wr_burst_len_1),
        .wr_ready_1(wr_ready_1), .wr_fifo_re_1(wr_fifo_re_1), .wr_fifo_data_1(wr_fifo_data_1),
        .wr_burst_finish_1(wr_burst_finish_1),
        .rd_burst_req_1(rd_burst_req_1), .rd_burst_addr_1(rd_burst_addr_1), .rd_burst_len_1(rd_burst_len_1),
        .rd_ready_1(rd_ready_1), .rd_fifo_we_1(rd_fifo_we_1), .rd_fifo_data_1(rd_fifo_data_1),
        .rd_burst_finish_1(rd_burst_finish_1),
        .m_wr_burst_req(m_wr_burst_req), .m_wr_burst_addr(m_wr_burst_addr), .m_wr_burst_len(m_wr_burst_len),
        .m_wr_ready(m_wr_ready), .m_wr_fifo_re(m_wr_fifo_re), .m_wr_fifo_data(m_wr_fifo_data),
        .m_wr_burst_finish(m_wr_burst_finish),
        .m_rd_burst_req(m_rd_burst_req), .m_rd_burst_addr(m_rd_burst_addr), .m_rd_burst_len(m_rd_burst_len),
        .m_rd_ready(m_rd_ready), .m_rd_fifo_we(m_rd_fifo_we), .m_rd_fifo_data(m_rd_fifo_data),
        .m_rd_burst_finish(m_rd_burst_finish),
        .grant_id(grant_id), .busy(busy), .proto_err(proto_err)
    );

    initial ui_clk = 1'b0;
    always #5 ui_clk = ~ui_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    // Ready outputs packed as {rd1, wr1, rd0, wr0}.
    function automatic logic [3:0] readies();
        return {rd_ready_1, wr_ready_1, rd_ready_0, wr_ready_0};
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, 64'(readies()), 64'hF);
        chk({tag, "_mreq"}, 64'({m_wr_burst_req, m_rd_burst_req}), 64'h0);
        chk({tag, "_perr"}, 64'(proto_err), 64'h0);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_gid"}, 64'(grant_id), 64'h0);
        chk({tag, "_addr"}, 64'({m_wr_burst_addr, m_rd_burst_len}), 64'h0);
    endtask

    // One burst with all requests held: ISSUE, BUSY, finish, back to IDLE.
    task automatic run_burst(input logic [1:0] exp_id, input string tag);
        tick();
        chk({tag, "_gid"}, 64'(grant_id), 64'(exp_id));
        if (exp_id[0] == 1'b0) chk({tag, "_wreq"}, 64'(m_wr_burst_req), 64'h1);
        else                   chk({tag, "_rreq"}, 64'(m_rd_burst_req), 64'h1);
        tick();
        if (exp_id[0] == 1'b0) m_wr_burst_finish = 1'b1;
        else                   m_rd_burst_finish = 1'b1;
        #1;
        chk({tag, "_fin"}, 64'({rd_burst_finish_1, wr_burst_finish_1, rd_burst_finish_0, wr_burst_finish_0}),
            64'(4'b0001 << exp_id));
        tick();
        m_wr_burst_finish = 1'b0;
        m_rd_burst_finish = 1'b0;
        chk({tag, "_idle"}, 64'(readies()), 64'hF);
    endtask

    initial begin
        ui_rst_n = 1'b0;
        {wr_burst_req_0, rd_burst_req_0, wr_burst_req_1, rd_burst_req_1} = 4'b0000;
        wr_burst_addr_0 = 32'h0000_1000; wr_burst_len_0 = 10'd8;
        rd_burst_addr_0 = 32'h0000_2000; rd_burst_len_0 = 10'd16;
        wr_burst_addr_1 = 32'h0000_4000; wr_burst_len_1 = 10'd128;
        rd_burst_addr_1 = 32'h0000_8000; rd_burst_len_1 = 10'd32;
        wr_fifo_data_0 = 64'h0;  wr_fifo_data_1 = 64'h0;
        m_wr_ready = 1'b1; m_rd_ready = 1'b1;
        m_wr_fifo_re = 1'b0; m_rd_fifo_we = 1'b0;
        m_wr_burst_finish = 1'b0; m_rd_burst_finish = 1'b0;
        m_rd_fifo_data = 64'h0;

        // Reset
        repeat (3) tick();
        check_reset_values("rst_hold");
        ui_rst_n = 1'b1;
        tick();
        check_reset_values("rst_rel");

        // Single P1W write burst
        wr_burst_req_1 = 1'b1;
        tick();
        chk("w1_req", 64'(m_wr_burst_req), 64'h1);
        chk("w1_addr", 64'(m_wr_burst_addr), 64'h4000);
        chk("w1_len", 64'(m_wr_burst_len), 64'd128);
        chk("w1_gid", 64'(grant_id), 64'h2);
        chk("w1_rdy", 64'(readies()), 64'h0);
        chk("w1_rreq", 64'(m_rd_burst_req), 64'h0);
        wr_burst_req_1 = 1'b0;
        tick();
        chk("w1_req_pulse", 64'(m_wr_burst_req), 64'h0);
        chk("w1_busy", 64'(busy), 64'h1);
        re0_cnt = 0; re1_cnt = 0;
        for (int i = 0; i < 128; i++) begin
            m_wr_fifo_re = 1'b1;
            wr_fifo_data_1 = 64'hA5A5_0000_0000_0000 + 64'(i);
            wr_fifo_data_0 = 64'h5A5A_0000_0000_0000 + 64'(i);
            #1;
            if (wr_fifo_re_1) re1_cnt++;
            if (wr_fifo_re_0) re0_cnt++;
            if (i == 77) chk("w1_data", m_wr_fifo_data, 64'hA5A5_0000_0000_004D);
            tick();
        end
        m_wr_fifo_re = 1'b0;
        chk("w1_re1_cnt", 64'(re1_cnt), 64'd128);
        chk("w1_re0_cnt", 64'(re0_cnt), 64'd0);
        m_wr_burst_finish = 1'b1;
        #1;
        chk("w1_fin", 64'({rd_burst_finish_1, wr_burst_finish_1, rd_burst_finish_0, wr_burst_finish_0}), 64'b0100);
        tick();
        m_wr_burst_finish = 1'b0;
        chk("w1_idle", 64'(readies()), 64'hF);
        chk("w1_perr", 64'(proto_err), 64'h0);

        // All four held, from a fresh reset so P0W leads
        ui_rst_n = 1'b0;
        #1;
        ui_rst_n = 1'b1;
        {wr_burst_req_0, rd_burst_req_0, wr_burst_req_1, rd_burst_req_1} = 4'b1111;
        run_burst(2'd0, "rr0");
        run_burst(2'd1, "rr1");
        run_burst(2'd2, "rr2");
        run_burst(2'd3, "rr3");
        run_burst(2'd0, "rr4");
        {wr_burst_req_0, rd_burst_req_0, wr_burst_req_1, rd_burst_req_1} = 4'b0000;

        // Engine not ready: P0R waits, request dropped during ISSUE
        m_rd_ready = 1'b0;
        rd_burst_req_0 = 1'b1;
        rd_burst_addr_0 = 32'h1234_5678;
        tick();
        rd_burst_req_0 = 1'b0;
        chk("nr_gid", 64'(grant_id), 64'h1);
        for (int i = 0; i < 10; i++) begin
            chk("nr_hold", 64'(m_rd_burst_req), 64'h0);
            tick();
        end
        m_rd_ready = 1'b1;
        #1;
        chk("nr_pulse", 64'(m_rd_burst_req), 64'h1);
        chk("nr_addr", 64'(m_rd_burst_addr), 64'h1234_5678);
        tick();
        chk("nr_pulse_end", 64'(m_rd_burst_req), 64'h0);
        m_rd_fifo_we = 1'b1;
        m_rd_fifo_data = 64'hDEAD_BEEF_0BAD_F00D;
        #1;
        chk("nr_we", 64'({rd_fifo_we_1, rd_fifo_we_0}), 64'b01);
        chk("nr_data", rd_fifo_data_1, 64'hDEAD_BEEF_0BAD_F00D);
        m_rd_fifo_we = 1'b0;
        m_rd_burst_finish = 1'b1;
        #1;
        chk("nr_fin", 64'({rd_burst_finish_1, rd_burst_finish_0}), 64'b01);
        tick();
        m_rd_burst_finish = 1'b0;
        chk("nr_idle", 64'(busy), 64'h0);

        // Protocol error: read finish during P0W burst
        wr_burst_req_0 = 1'b1;
        tick();
        wr_burst_req_0 = 1'b0;
        chk("pe_gid", 64'(grant_id), 64'h0);
        tick();
        m_rd_burst_finish = 1'b1;
        #1;
        chk("pe_nofin", 64'({rd_burst_finish_1, wr_burst_finish_1, rd_burst_finish_0, wr_burst_finish_0}), 64'h0);
        tick();
        m_rd_burst_finish = 1'b0;
        chk("pe_set", 64'(proto_err), 64'h1);
        chk("pe_busy", 64'(busy), 64'h1);
        m_wr_burst_finish = 1'b1;
        #1;
        chk("pe_wfin", 64'(wr_burst_finish_0), 64'h1);
        tick();
        m_wr_burst_finish = 1'b0;
        chk("pe_idle", 64'(busy), 64'h0);
        chk("pe_sticky", 64'(proto_err), 64'h1);

        // Mid-burst reset during P1R
        rd_burst_req_1 = 1'b1;
        tick();
        chk("mr_gid", 64'(grant_id), 64'h3);
        tick();
        chk("mr_busy", 64'(busy), 64'h1);
        ui_rst_n = 1'b0;
        #1;
        check_reset_values("mr_rst");
        tick();
        ui_rst_n = 1'b1;
        wr_burst_req_0 = 1'b1;
        tick();
        chk("mr_next_gid", 64'(grant_id), 64'h0);
        chk("mr_next_req", 64'(m_wr_burst_req), 64'h1);
        chk("mr_next_addr", 64'(m_wr_burst_addr), 64'h1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
